// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle RISC-V core front end.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] INSN_BYTES   = 32'd4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC = 32'h0000_0100;

endpackage

// File: rtl/fetch_pc_next.sv
// Next-PC selection at retire: sequential, branch/jump redirect, or trap on a misaligned target.
module fetch_pc_next
  import cpu_pkg::*;
#(
  parameter logic [31:0] TRAP_VEC = DEF_TRAP_VEC
) (
  input  logic [31:0] pc_i,
  input  logic        ex_branch_i,
  input  logic        branch_taken_i,
  input  logic        ex_jump_i,
  input  logic [31:0] ex_target_i,
  output logic [31:0] tgt_o,
  output logic        misaligned_o,
  output logic [31:0] pc_next_o
);

  logic redirect;

  assign redirect = ex_jump_i | (ex_branch_i & branch_taken_i);
  // Bit 0 is dropped for every target (JALR semantics); only bit 1 can misalign.
  assign tgt_o        = ex_target_i & 32'hFFFF_FFFE;
  assign misaligned_o = redirect & tgt_o[1];

  always_comb begin
    pc_next_o = pc_i + INSN_BYTES;
    if (misaligned_o)  pc_next_o = TRAP_VEC;
    else if (redirect) pc_next_o = tgt_o;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, one-at-a-time imem fetch FSM, retire bookkeeping.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] TRAP_VEC = DEF_TRAP_VEC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        ex_branch,
  input  logic        branch_taken,
  input  logic        ex_jump,
  input  logic [31:0] ex_target,
  output logic        trap,
  output logic [31:0] trap_tval,
  output logic [31:0] retire_count
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, inst_q, inst_pc_q, tval_q, cnt_q;
  logic         trap_q;
  logic         retire, capture, misaligned;
  logic [31:0]  tgt, pc_next;

  assign retire  = (state_q == HOLD) & inst_ready;
  assign capture = (state_q == WAIT) & imem_rsp_valid;

  fetch_pc_next #(.TRAP_VEC(TRAP_VEC)) u_pc_next (
    .pc_i           (pc_q),
    .ex_branch_i    (ex_branch),
    .branch_taken_i (branch_taken),
    .ex_jump_i      (ex_jump),
    .ex_target_i    (ex_target),
    .tgt_o          (tgt),
    .misaligned_o   (misaligned),
    .pc_next_o      (pc_next)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (imem_req_ready) state_d = WAIT;
      WAIT:    if (imem_rsp_valid) state_d = HOLD;
      HOLD:    if (inst_ready)     state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= '0;
      tval_q    <= '0;
      cnt_q     <= '0;
      trap_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      trap_q  <= retire & misaligned;
      if (capture) begin
        inst_q    <= imem_rsp_data;
        inst_pc_q <= pc_q;
      end
      // PC only moves on retire, so imem_addr is stable across FETCH/WAIT.
      if (retire) begin
        pc_q  <= pc_next;
        cnt_q <= cnt_q + 32'd1;
        if (misaligned) tval_q <= tgt;
      end
    end
  end

  assign imem_req_valid = (state_q == FETCH);
  assign imem_addr      = pc_q;
  assign inst_valid     = (state_q == HOLD);
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign trap           = trap_q;
  assign trap_tval      = tval_q;
  assign retire_count   = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a transaction-level model, plus directed literal checks.
module tb_fetch_unit;
  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] TV  = 32'h0000_0100;

  logic        clk = 1'b0, rst_n = 1'b1;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_addr, imem_rsp_data;
  logic        inst_valid, inst_ready, ex_branch, branch_taken, ex_jump, trap;
  logic [31:0] inst, inst_pc, ex_target, trap_tval, retire_count;

  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .TRAP_VEC(TV)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .ex_branch(ex_branch), .branch_taken(branch_taken), .ex_jump(ex_jump), .ex_target(ex_target),
    .trap(trap), .trap_tval(trap_tval), .retire_count(retire_count)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Model: phase 0 idle, 1 request outstanding, 2 awaiting data, 3 instruction presented.
  int          m_ph   = 0;
  logic [31:0] m_pc   = RPC, m_inst = 0, m_ipc = 0, m_tval = 0, m_cnt = 0;
  logic        m_trap = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = 0; m_pc = RPC; m_inst = 0; m_ipc = 0; m_tval = 0; m_cnt = 0; m_trap = 0;
    end else begin
      logic        redir;
      logic [31:0] t;
      m_trap = 0;
      if (m_ph == 0) m_ph = 1;
      else if (m_ph == 1) begin
        if (imem_req_ready) m_ph = 2;
      end else if (m_ph == 2) begin
        if (imem_rsp_valid) begin m_inst = imem_rsp_data; m_ipc = m_pc; m_ph = 3; end
      end else if (inst_ready) begin
        redir = ex_jump || (ex_branch && branch_taken);
        t     = ex_target - (ex_target % 2);
        m_cnt = m_cnt + 1;
        m_ph  = 1;
        if (redir && (t % 4) != 0) begin m_pc = TV; m_trap = 1; m_tval = t; end
        else if (redir) m_pc = t;
        else m_pc = m_pc + 4;
      end
    end
  end

  always @(negedge clk) begin
    chk("imem_req_valid", 32'(imem_req_valid), 32'(m_ph == 1));
    chk("imem_addr", imem_addr, m_pc);
    chk("inst_valid", 32'(inst_valid), 32'(m_ph == 3));
    chk("inst", inst, m_inst);
    chk("inst_pc", inst_pc, m_ipc);
    chk("trap", 32'(trap), 32'(m_trap));
    chk("trap_tval", trap_tval, m_tval);
    chk("retire_count", retire_count, m_cnt);
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  // Drives one full instruction starting in FETCH; noise on ignored inputs throughout.
  task automatic do_insn(input int rl, input int sl, input logic [31:0] d, input int st,
                         input logic br, input logic tk, input logic jp, input logic [31:0] tg);
    repeat (rl) begin
      imem_req_ready = 0; imem_rsp_valid = 1'($urandom); imem_rsp_data = $urandom;
      inst_ready = 1'($urandom); tick();
    end
    imem_req_ready = 1; imem_rsp_valid = 1'($urandom); imem_rsp_data = $urandom;
    inst_ready = 1'($urandom); tick();
    imem_req_ready = 0;
    repeat (sl) begin
      imem_rsp_valid = 0; imem_req_ready = 1'($urandom); inst_ready = 1'($urandom); tick();
    end
    imem_rsp_valid = 1; imem_rsp_data = d; inst_ready = 0; tick();
    imem_rsp_valid = 0; imem_req_ready = 0;
    repeat (st) begin
      inst_ready = 0; {ex_branch, branch_taken, ex_jump} = 3'($urandom); ex_target = $urandom;
      imem_rsp_valid = 1'($urandom); imem_rsp_data = $urandom; tick();
    end
    imem_rsp_valid = 0;
    ex_branch = br; branch_taken = tk; ex_jump = jp; ex_target = tg; inst_ready = 1; tick();
    inst_ready = 0; {ex_branch, branch_taken, ex_jump} = 3'($urandom); ex_target = $urandom;
  endtask

  initial begin
    logic [31:0] tg;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0; inst_ready = 0;
    ex_branch = 0; branch_taken = 0; ex_jump = 0; ex_target = 0;
    #1 rst_n = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst req_valid", 32'(imem_req_valid), 0);
    chk("rst addr", imem_addr, RPC);
    chk("rst count", retire_count, 0);
    chk("rst inst", inst, 0);
    rst_n = 1;
    tick();
    chk("c1 req_valid", 32'(imem_req_valid), 1);
    chk("c1 addr", imem_addr, 32'h0);
    imem_req_ready = 1; imem_rsp_valid = 1; imem_rsp_data = 32'h0000_0013;
    tick(); tick();
    chk("c3 inst_valid", 32'(inst_valid), 1);
    chk("c3 inst", inst, 32'h0000_0013);
    imem_req_ready = 0; imem_rsp_valid = 0; inst_ready = 1;
    tick();
    inst_ready = 0;
    chk("seq addr", imem_addr, 32'h4);
    chk("seq count", retire_count, 1);

    do_insn(3, 2, 32'hAAAA_0001, 0, 0, 0, 0, 0);
    chk("backpressure addr", imem_addr, 32'h8);
    do_insn(0, 0, 32'h1, 0, 0, 0, 1, 32'h10);
    do_insn(0, 0, 32'h2, 0, 1, 1, 0, 32'h40);
    chk("taken addr", imem_addr, 32'h40);
    do_insn(0, 0, 32'h3, 0, 0, 0, 1, 32'h10);
    do_insn(0, 0, 32'h4, 0, 1, 0, 0, 32'h40);
    chk("not-taken addr", imem_addr, 32'h14);
    do_insn(0, 0, 32'h5, 0, 0, 0, 1, 32'h33);
    chk("trap pulse", 32'(trap), 1);
    chk("trap tval", trap_tval, 32'h32);
    chk("trap addr", imem_addr, TV);
    tick();
    chk("trap one cycle", 32'(trap), 0);
    chk("tval held", trap_tval, 32'h32);
    do_insn(0, 0, 32'hDEAD_BEEF, 5, 0, 0, 0, 0);
    chk("stall inst_pc", inst_pc, TV);
    chk("stall inst", inst, 32'hDEAD_BEEF);
    do_insn(0, 0, 32'h6, 0, 0, 0, 1, 32'hFFFF_FFFC);
    chk("pre-wrap addr", imem_addr, 32'hFFFF_FFFC);
    do_insn(1, 1, 32'h7, 0, 0, 0, 0, 0);
    chk("wrap addr", imem_addr, 32'h0);
    do_insn(0, 0, 32'h8, 0, 0, 0, 0, 0);

    imem_req_ready = 1; tick();
    imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = 32'h1234_5678;
    rst_n = 0; #1;
    chk("wait-rst addr", imem_addr, RPC);
    chk("wait-rst count", retire_count, 0);
    chk("wait-rst inst_pc", inst_pc, 0);
    chk("wait-rst tval", trap_tval, 0);
    tick(); tick();
    rst_n = 1; #1;
    chk("post-rst req_valid", 32'(imem_req_valid), 0);
    imem_rsp_valid = 0;
    tick();
    chk("post-rst fetch", 32'(imem_req_valid), 1);
    chk("post-rst addr", imem_addr, RPC);

    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 3))
        0:       tg = $urandom & ~32'h3;
        1:       tg = ($urandom & ~32'h3) | 32'h1;
        2:       tg = $urandom | 32'h2;
        default: tg = $urandom;
      endcase
      do_insn($urandom_range(0, 3), $urandom_range(0, 3), $urandom, $urandom_range(0, 2),
              1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), tg);
    end
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
